// File: rtl/tlb_search_arbiter_pkg.sv
// Shared constants for the TLB search arbiter: requester indices, response word
// layout and the per-slot state encoding.
package tlb_search_arbiter_pkg;

    typedef logic [1:0] req_id_t;

    localparam int      NUM_REQ  = 3;
    localparam req_id_t REQ_IF   = 2'd0;
    localparam req_id_t REQ_MEM  = 2'd1;
    localparam req_id_t REQ_SRCH = 2'd2;

    localparam int DEF_TLBIDX_W     = 4;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int RESP_W           = 33 + DEF_TLBIDX_W;

    // Response word is {found, index, ppn, ps, plv, mat, d, v}, v at bit 0.
    localparam int OFF_V     = 0;
    localparam int OFF_D     = 1;
    localparam int OFF_MAT   = 2;
    localparam int OFF_PLV   = 4;
    localparam int OFF_PS    = 6;
    localparam int OFF_PPN   = 12;
    localparam int OFF_INDEX = 32;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int resp_w(input int idx_w);
        return 33 + idx_w;
    endfunction

    function automatic int off_found(input int idx_w);
        return OFF_INDEX + idx_w;
    endfunction

endpackage

// File: rtl/tlb_search_arbiter_if.sv
// Bundle of requester handshakes, the TLB search port and the response slots.
// slave is the arbiter's view; master is the pipeline/TLB side.
interface tlb_search_arbiter_if #(
    parameter int TLBIDX_W = tlb_search_arbiter_pkg::DEF_TLBIDX_W
);
    import tlb_search_arbiter_pkg::*;

    localparam int RW = resp_w(TLBIDX_W);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_va;
    logic [NUM_REQ-1:0]    flush;
    logic [9:0]            csr_asid;

    logic [18:0]           s_vppn;
    logic                  s_va_bit12;
    logic [9:0]            s_asid;
    logic                  s_found;
    logic [TLBIDX_W-1:0]   s_index;
    logic [19:0]           s_ppn;
    logic [5:0]            s_ps;
    logic [1:0]            s_plv;
    logic [1:0]            s_mat;
    logic                  s_d;
    logic                  s_v;

    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [NUM_REQ*RW-1:0] resp_data;

    modport slave (
        input  req_valid, req_va, flush, csr_asid,
        input  s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        input  resp_ready,
        output req_ready, s_vppn, s_va_bit12, s_asid,
        output resp_valid, resp_data
    );

    modport master (
        output req_valid, req_va, flush, csr_asid,
        output s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
        output resp_ready,
        input  req_ready, s_vppn, s_va_bit12, s_asid,
        input  resp_valid, resp_data
    );

endinterface

// File: rtl/tlb_resp_slot.sv
// One response register holding a captured TLB lookup until its consumer takes
// it; a flush empties the slot and wins over a same-cycle capture.
module tlb_resp_slot
    import tlb_search_arbiter_pkg::*;
#(
    parameter int W = RESP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture,
    input  logic [W-1:0] capture_data,
    input  logic         take,
    input  logic         flush,
    output logic         valid,
    output logic [W-1:0] data
);

    slot_state_e  state_q;
    slot_state_e  state_d;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A capture landing on the edge that the consumer takes the old word keeps the slot full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (capture && !flush) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (flush) begin
                    state_d = SLOT_EMPTY;
                end else if (take && !capture) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (capture && !flush) begin
            data_q <= capture_data;
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares the TLB search port between IF, MEM and SRCH through a one-entry search
// stage and three per-requester response slots.
module tlb_search_arbiter
    import tlb_search_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TLBIDX_W     = DEF_TLBIDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    tlb_search_arbiter_if.slave  bus
);

    localparam int RW          = resp_w(TLBIDX_W);
    localparam int OFF_FOUND_L = off_found(TLBIDX_W);
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic               sv_q;
    req_id_t            sid_q;
    logic [19:0]        vpage_q;
    logic [9:0]         asid_q;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [CNT_W-1:0]   starve_cnt_d;

    logic [NUM_REQ-1:0] sid_onehot;
    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] capture;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               slot_free;
    logic               stage_flushed;
    logic               advance;
    logic               can_accept;
    logic               starved;
    req_id_t            win_id;
    logic [19:0]        win_vpage;
    logic [RW-1:0]      tlb_result;
    logic [RW-1:0]      slot_data [NUM_REQ];
    logic               unused_va_lo;

    assign unused_va_lo = ^{bus.req_va[75:64], bus.req_va[43:32], bus.req_va[11:0]};

    // A flushed entry frees the stage just like an advance, so another requester can refill it.
    assign sid_onehot    = sv_q ? (NUM_REQ'(1) << sid_q) : '0;
    assign slot_free     = |(sid_onehot & (~slot_valid | bus.resp_ready));
    assign stage_flushed = |(sid_onehot & bus.flush);
    assign advance       = slot_free & ~stage_flushed;
    assign can_accept    = ~sv_q | advance | stage_flushed;
    assign capture       = advance ? sid_onehot : '0;
    assign starved       = (starve_cnt_q == STARVE_MAX);

    // Fixed priority SRCH > MEM > IF, except a starved IF jumps ahead of MEM.
    always_comb begin
        eligible = bus.req_valid & ~bus.flush & {NUM_REQ{can_accept & ~reset}};
        grant    = '0;
        win_id   = REQ_IF;
        if (eligible[REQ_SRCH]) begin
            grant[REQ_SRCH] = 1'b1;
            win_id          = REQ_SRCH;
        end else if (starved && eligible[REQ_IF]) begin
            grant[REQ_IF] = 1'b1;
            win_id        = REQ_IF;
        end else if (eligible[REQ_MEM]) begin
            grant[REQ_MEM] = 1'b1;
            win_id         = REQ_MEM;
        end else if (eligible[REQ_IF]) begin
            grant[REQ_IF] = 1'b1;
            win_id        = REQ_IF;
        end
    end

    always_comb begin
        win_vpage = bus.req_va[31:12];
        case (win_id)
            REQ_MEM:  win_vpage = bus.req_va[63:44];
            REQ_SRCH: win_vpage = bus.req_va[95:76];
            default:  win_vpage = bus.req_va[31:12];
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.req_valid[REQ_IF] || bus.flush[REQ_IF] || grant[REQ_IF]) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv_q    <= 1'b0;
            sid_q   <= REQ_IF;
            vpage_q <= '0;
            asid_q  <= '0;
        end else if (|grant) begin
            sv_q    <= 1'b1;
            sid_q   <= win_id;
            vpage_q <= win_vpage;
            asid_q  <= bus.csr_asid;
        end else if (advance || stage_flushed) begin
            sv_q    <= 1'b0;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.s_vppn     = sv_q ? vpage_q[19:1] : '0;
    assign bus.s_va_bit12 = sv_q & vpage_q[0];
    assign bus.s_asid     = sv_q ? asid_q : '0;

    always_comb begin
        tlb_result                           = '0;
        tlb_result[OFF_V]                    = bus.s_v;
        tlb_result[OFF_D]                    = bus.s_d;
        tlb_result[OFF_MAT +: 2]             = bus.s_mat;
        tlb_result[OFF_PLV +: 2]             = bus.s_plv;
        tlb_result[OFF_PS +: 6]              = bus.s_ps;
        tlb_result[OFF_PPN +: 20]            = bus.s_ppn;
        tlb_result[OFF_INDEX +: TLBIDX_W]    = bus.s_index;
        tlb_result[OFF_FOUND_L]              = bus.s_found;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        tlb_resp_slot #(
            .W (RW)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .capture      (capture[i]),
            .capture_data (tlb_result),
            .take         (bus.resp_ready[i]),
            .flush        (bus.flush[i]),
            .valid        (slot_valid[i]),
            .data         (slot_data[i])
        );
    end

    assign bus.resp_valid = slot_valid;

    always_comb begin
        bus.resp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.resp_data[i*RW +: RW] = slot_data[i];
        end
    end

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter: a behavioural TLB answers the search
// port, and a scoreboard monitor checks every response handshake.
module tb_tlb_search_arbiter;
    import tlb_search_arbiter_pkg::*;

    localparam int IW = 4;
    localparam int RW = 33 + IW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [RW-1:0] exp_if_q[$];
    logic [RW-1:0] exp_mem_q[$];
    logic [RW-1:0] exp_srch_q[$];

    tlb_search_arbiter_if #(.TLBIDX_W(IW)) bus ();

    tlb_search_arbiter #(
        .STARVE_LIMIT (4),
        .TLBIDX_W     (IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hit unless vppn[18:16] is all ones; other fields mix vppn, bit 12 and asid.
    function automatic logic [RW-1:0] tlb_model(input logic [18:0] vppn, input logic bit12,
                                                input logic [9:0] asid);
        logic        found;
        logic [3:0]  idx;
        logic [19:0] ppn;
        logic [5:0]  ps;
        found = (vppn[18:16] != 3'b111);
        idx   = vppn[3:0] ^ {1'b0, asid[3:1]};
        ppn   = {vppn, bit12} ^ {10'h000, asid};
        ps    = vppn[4] ? 6'd21 : 6'd12;
        return {found, idx, ppn, ps, asid[1:0], vppn[6:5], bit12, found};
    endfunction

    always_comb begin
        {bus.s_found, bus.s_index, bus.s_ppn, bus.s_ps, bus.s_plv, bus.s_mat, bus.s_d, bus.s_v}
            = tlb_model(bus.s_vppn, bus.s_va_bit12, bus.s_asid);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int id, input logic [RW-1:0] v);
        case (id)
            0:       exp_if_q.push_back(v);
            1:       exp_mem_q.push_back(v);
            default: exp_srch_q.push_back(v);
        endcase
    endtask

    task automatic popExpected(input int id, output bit ok, output logic [RW-1:0] v);
        ok = 1'b0;
        v  = '0;
        case (id)
            0: if (exp_if_q.size() > 0) begin v = exp_if_q.pop_front(); ok = 1'b1; end
            1: if (exp_mem_q.size() > 0) begin v = exp_mem_q.pop_front(); ok = 1'b1; end
            default: if (exp_srch_q.size() > 0) begin v = exp_srch_q.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] va, input bit expect_resp);
        bus.req_valid[id]      = 1'b1;
        bus.req_va[id*32 +: 32] = va;
        if (expect_resp) begin
            pushExpected(id, tlb_model(va[31:13], va[12], bus.csr_asid));
        end
    endtask

    task automatic dropReq(input int id);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [RW-1:0] want;
        bit            have;
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.resp_valid[i] && bus.resp_ready[i]) begin
                    popExpected(i, have, want);
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL resp_unexpected slot %0d: got 0x%0h, expected no response",
                                 i, bus.resp_data[i*RW +: RW]);
                    end else begin
                        checkOutput($sformatf("resp_slot%0d", i), 64'(bus.resp_data[i*RW +: RW]), 64'(want));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.req_valid  = 3'b111;
        bus.req_va     = '0;
        bus.flush      = '0;
        bus.csr_asid   = 10'h005;
        bus.resp_ready = '0;

        @(negedge clk);
        checkOutput("reset_req_ready", bus.req_ready, 0);
        checkOutput("reset_resp_valid", bus.resp_valid, 0);
        checkOutput("reset_s_vppn", bus.s_vppn, 0);
        checkOutput("reset_resp_data", bus.resp_data[63:0], 0);
        bus.req_valid = '0;
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] test 1: single IF lookup");
        bus.resp_ready = 3'b111;
        applyStimulus(REQ_IF, 32'h1C00_3000, 1'b1);
        @(negedge clk);
        checkOutput("t1_accept", bus.req_ready, 3'b001);
        tick();
        dropReq(REQ_IF);
        @(negedge clk);
        checkOutput("t1_s_vppn", bus.s_vppn, 19'h0E001);
        checkOutput("t1_s_va_bit12", bus.s_va_bit12, 1'b1);
        checkOutput("t1_s_asid", bus.s_asid, 10'h005);
        checkOutput("t1_no_resp_yet", bus.resp_valid, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("t1_resp_valid", bus.resp_valid, 3'b001);
        checkOutput("t1_found_index", bus.resp_data[36:32], 5'h13);

        $display("[TB] test 2: three-way contention");
        tick();
        applyStimulus(REQ_IF,   32'h0000_0000, 1'b1);
        applyStimulus(REQ_MEM,  32'hE000_2000, 1'b1);
        applyStimulus(REQ_SRCH, 32'h0012_5000, 1'b1);
        @(negedge clk);
        checkOutput("t2_ready_srch", bus.req_ready, 3'b100);
        tick();
        dropReq(REQ_SRCH);
        @(negedge clk);
        checkOutput("t2_ready_mem", bus.req_ready, 3'b010);
        tick();
        dropReq(REQ_MEM);
        @(negedge clk);
        checkOutput("t2_ready_if", bus.req_ready, 3'b001);
        checkOutput("t2_resp_srch", bus.resp_valid, 3'b100);
        tick();
        dropReq(REQ_IF);
        @(negedge clk);
        checkOutput("t2_resp_mem", bus.resp_valid, 3'b010);
        tick();
        @(negedge clk);
        checkOutput("t2_resp_if", bus.resp_valid, 3'b001);

        $display("[TB] test 3: IF starvation");
        tick();
        applyStimulus(REQ_IF, 32'h0000_1000, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(REQ_MEM, 32'h0040_0000 + (k << 12), 1'b1);
            @(negedge clk);
            checkOutput($sformatf("t3_ready_cycle%0d", k), bus.req_ready, (k < 5) ? 3'b010 : 3'b001);
            tick();
        end
        dropReq(REQ_IF);
        @(negedge clk);
        checkOutput("t3_ready_mem_after", bus.req_ready, 3'b010);
        checkOutput("t3_starve_cleared", dut.starve_cnt_q, 0);
        tick();
        dropReq(REQ_MEM);
        tick();
        tick();
        tick();

        $display("[TB] test 4: back-pressure stall");
        bus.resp_ready = 3'b101;
        applyStimulus(REQ_MEM, 32'h0ABC_D000, 1'b1);
        @(negedge clk);
        checkOutput("t4_accept_a", bus.req_ready, 3'b010);
        tick();
        applyStimulus(REQ_MEM, 32'h0123_4000, 1'b1);
        @(negedge clk);
        checkOutput("t4_accept_b", bus.req_ready, 3'b010);
        tick();
        dropReq(REQ_MEM);
        applyStimulus(REQ_IF, 32'h7FFF_F000, 1'b1);
        @(negedge clk);
        checkOutput("t4_stall_ready", bus.req_ready, 3'b000);
        checkOutput("t4_stall_resp", bus.resp_valid, 3'b010);
        checkOutput("t4_stall_vppn", bus.s_vppn, 19'h0091A);
        tick();
        @(negedge clk);
        checkOutput("t4_stall_ready2", bus.req_ready, 3'b000);
        checkOutput("t4_stall_vppn2", bus.s_vppn, 19'h0091A);
        checkOutput("t4_stall_bit12", bus.s_va_bit12, 1'b0);
        tick();
        bus.resp_ready = 3'b111;
        @(negedge clk);
        checkOutput("t4_release_ready", bus.req_ready, 3'b001);
        tick();
        dropReq(REQ_IF);
        @(negedge clk);
        checkOutput("t4_resp_b", bus.resp_valid, 3'b010);
        tick();
        @(negedge clk);
        checkOutput("t4_resp_c", bus.resp_valid, 3'b001);
        tick();
        @(negedge clk);
        checkOutput("t4_idle", bus.resp_valid, 3'b000);

        $display("[TB] test 5: flush of in-flight IF");
        tick();
        applyStimulus(REQ_IF, 32'h0020_0000, 1'b0);
        @(negedge clk);
        checkOutput("t5_accept_if", bus.req_ready, 3'b001);
        tick();
        dropReq(REQ_IF);
        bus.flush = 3'b001;
        applyStimulus(REQ_MEM, 32'h0030_1000, 1'b1);
        @(negedge clk);
        checkOutput("t5_accept_mem", bus.req_ready, 3'b010);
        tick();
        bus.flush = 3'b000;
        dropReq(REQ_MEM);
        @(negedge clk);
        checkOutput("t5_no_if_resp", bus.resp_valid, 3'b000);
        tick();
        @(negedge clk);
        checkOutput("t5_mem_resp", bus.resp_valid, 3'b010);
        tick();
        @(negedge clk);
        checkOutput("t5_idle", bus.resp_valid, 3'b000);

        $display("[TB] test 6: asynchronous reset mid-search");
        tick();
        bus.resp_ready = 3'b011;
        applyStimulus(REQ_SRCH, 32'h0055_5000, 1'b0);
        @(negedge clk);
        checkOutput("t6_accept_x", bus.req_ready, 3'b100);
        tick();
        applyStimulus(REQ_SRCH, 32'h0066_6000, 1'b0);
        @(negedge clk);
        checkOutput("t6_accept_y", bus.req_ready, 3'b100);
        tick();
        dropReq(REQ_SRCH);
        @(negedge clk);
        checkOutput("t6_slot2_full", bus.resp_valid, 3'b100);
        checkOutput("t6_stage_vppn", bus.s_vppn, 19'h00333);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6_reset_resp_valid", bus.resp_valid, 3'b000);
        checkOutput("t6_reset_req_ready", bus.req_ready, 3'b000);
        checkOutput("t6_reset_s_vppn", bus.s_vppn, 0);
        checkOutput("t6_reset_slot2_data", bus.resp_data[3*RW-1 -: RW], 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.resp_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_no_resp_%0d", k), bus.resp_valid, 3'b000);
        end

        checkOutput("sb_if_drained", exp_if_q.size(), 0);
        checkOutput("sb_mem_drained", exp_mem_q.size(), 0);
        checkOutput("sb_srch_drained", exp_srch_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
